// File: rtl/mig_pkg.sv
// Shared types and constants for the MIG truth-table sequencer.
// Operand/node encodings, select decode points and FSM states.
package mig_pkg;

  localparam int MAX_NODES = 16;
  localparam int SELW      = 5;
  localparam int AW        = $clog2(MAX_NODES);
  localparam int NW        = AW + 1;
  localparam int NODEW     = 3 * (1 + SELW);

  localparam logic [SELW-1:0] SEL_CONST0 = SELW'(0);
  localparam logic [SELW-1:0] SEL_X0     = SELW'(1);
  localparam logic [SELW-1:0] SEL_NODE0  = SELW'(8);

  typedef struct packed {
    logic            inv;
    logic [SELW-1:0] sel;
  } operand_t;

  // operand a sits in the LSBs
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } node_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/mig_maj3_unit.sv
// Shared MAJ3 evaluator: decodes three operands, applies inversion, votes.
// Ports: nw node word, x input vector, scr earlier node results, node index; y result, err bad ref.
module mig_maj3_unit
  import mig_pkg::*;
(
  input  node_t                nw,
  input  logic [6:0]           x,
  input  logic [MAX_NODES-1:0] scr,
  input  logic [AW-1:0]        node,
  output logic                 y,
  output logic                 err
);

  // returns {bad, value}; only strictly earlier nodes are readable
  function automatic logic [1:0] fetch(
    input operand_t             op,
    input logic [6:0]           xv,
    input logic [MAX_NODES-1:0] sv,
    input logic [AW-1:0]        n
  );
    logic            raw;
    logic            bad;
    logic [SELW-1:0] j;
    raw = 1'b0;
    bad = 1'b0;
    j   = op.sel - SEL_NODE0;
    if (op.sel == SEL_CONST0) begin
      raw = 1'b0;
    end else if (op.sel < SEL_NODE0) begin
      raw = xv[op.sel[2:0] - 3'd1];
    end else if (j < SELW'(n)) begin
      raw = sv[j[AW-1:0]];
    end else begin
      bad = 1'b1;
    end
    return {bad, raw ^ op.inv};
  endfunction

  logic [1:0] fa;
  logic [1:0] fb;
  logic [1:0] fc;

  always_comb begin
    fa  = fetch(nw.a, x, scr, node);
    fb  = fetch(nw.b, x, scr, node);
    fc  = fetch(nw.c, x, scr, node);
    y   = (fa[0] & fb[0]) | (fa[0] & fc[0]) | (fb[0] & fc[0]);
    err = fa[1] | fb[1] | fc[1];
  end

endmodule

// File: rtl/mig_tt_sequencer.sv
// Sweeps x0..x6 over a stored MIG program, one node per cycle, building a 128-bit truth table.
// Ports: program write, start/num_nodes, busy/done, per-vector out_valid/idx/bit, tt, prog_err.
module mig_tt_sequencer
  import mig_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [NODEW-1:0] prog_data,
  input  logic [NW-1:0]    num_nodes,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [6:0]       out_idx,
  output logic             out_bit,
  output logic [127:0]     tt,
  output logic             prog_err
);

  node_t                prog [MAX_NODES];
  logic [MAX_NODES-1:0] scr;
  logic [AW-1:0]        node;
  logic [6:0]           vec;
  logic [NW-1:0]        nn;
  state_e               state;

  logic y;
  logic err;
  logic last;
  logic nn_ok;

  // RAM is not reset; writes are blocked outside IDLE
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) begin
      prog[prog_addr] <= node_t'(prog_data);
    end
  end

  mig_maj3_unit u_maj (
    .nw   (prog[node]),
    .x    (vec),
    .scr  (scr),
    .node (node),
    .y    (y),
    .err  (err)
  );

  assign last  = ({1'b0, node} == nn - NW'(1));
  assign nn_ok = (num_nodes != '0) &&
                 (num_nodes <= NW'(MAX_NODES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_bit   <= 1'b0;
      tt        <= '0;
      prog_err  <= 1'b0;
      node      <= '0;
      vec       <= '0;
      nn        <= '0;
      scr       <= '0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (nn_ok) begin
              state    <= EVAL;
              busy     <= 1'b1;
              nn       <= num_nodes;
              node     <= '0;
              vec      <= '0;
              tt       <= '0;
              scr      <= '0;
              prog_err <= 1'b0;
            end else begin
              prog_err <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        EVAL: begin
          if (err) begin
            prog_err <= 1'b1;
          end
          scr[node] <= y;
          if (last) begin
            // vector complete: publish and restart node walk
            out_bit   <= y;
            out_valid <= 1'b1;
            out_idx   <= vec;
            tt[vec]   <= y;
            scr       <= '0;
            node      <= '0;
            vec       <= vec + 7'd1;
            if (vec == 7'd127) begin
              state <= DONE;
            end
          end else begin
            node <= node + AW'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
